// File: rtl/count_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : count_monitor_if
// Description : Sample/status bundle between a mod-8 counter source and
//               the count_monitor checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface count_monitor_if;
    logic [2:0] cnt_in;
    logic       en;
    logic       clr_err;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic       wrap_pulse;

    modport master (
        output cnt_in, en, clr_err,
        input  locked, err, err_cnt, wrap_cnt, wrap_pulse
    );

    modport slave (
        input  cnt_in, en, clr_err,
        output locked, err, err_cnt, wrap_cnt, wrap_pulse
    );
endinterface
`default_nettype wire

// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : count_monitor
// Description : Locks onto an upstream mod-8 count sequence, then tracks it,
//               counting mismatches and 7->0 wraps; sticky fault on a run of
//               consecutive mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module count_monitor #(
    parameter int SYNC_LEN   = 4,
    parameter int MISS_LIMIT = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    count_monitor_if.slave    mon
);

    localparam logic [3:0] c_sync_len   = 4'(SYNC_LEN);
    localparam logic [3:0] c_miss_limit = 4'(MISS_LIMIT);
    localparam logic [7:0] c_cnt_max    = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t     r_state,      w_state_nxt;
    logic [2:0] r_prev,       w_prev_nxt;
    logic [3:0] r_good_run,   w_good_run_nxt;
    logic [3:0] r_miss_run,   w_miss_run_nxt;
    logic       r_locked,     w_locked_nxt;
    logic       r_err,        w_err_nxt;
    logic [7:0] r_err_cnt,    w_err_cnt_nxt;
    logic [7:0] r_wrap_cnt,   w_wrap_cnt_nxt;
    logic       r_wrap_pulse, w_wrap_pulse_nxt;

    logic [2:0] w_prev_inc;
    logic       w_match;
    logic       w_wrap;
    logic [3:0] w_good_inc;
    logic [3:0] w_miss_inc;

    assign w_prev_inc = r_prev + 3'd1;
    assign w_match    = (mon.cnt_in == w_prev_inc);
    assign w_wrap     = (r_prev == 3'd7) && (mon.cnt_in == 3'd0);
    assign w_good_inc = r_good_run + 4'd1;
    assign w_miss_inc = r_miss_run + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_prev_nxt       = r_prev;
        w_good_run_nxt   = r_good_run;
        w_miss_run_nxt   = r_miss_run;
        w_err_nxt        = r_err;
        w_err_cnt_nxt    = r_err_cnt;
        w_wrap_cnt_nxt   = r_wrap_cnt;
        w_wrap_pulse_nxt = 1'b0;

        // A clear is applied first so that a mismatch or fault entry on
        // the same edge can override it below.
        if (mon.clr_err) begin
            w_err_nxt     = 1'b0;
            w_err_cnt_nxt = 8'd0;
        end

        if (!mon.en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_prev_nxt     = mon.cnt_in;
                    w_good_run_nxt = 4'd0;
                    w_state_nxt    = ST_SYNC;
                end
                ST_SYNC: begin
                    w_prev_nxt = mon.cnt_in;
                    if (w_match) begin
                        w_good_run_nxt = w_good_inc;
                        if (w_good_inc == c_sync_len) begin
                            w_miss_run_nxt = 4'd0;
                            w_state_nxt    = ST_TRACK;
                        end
                    end else begin
                        w_good_run_nxt = 4'd0;
                    end
                end
                ST_TRACK: begin
                    w_prev_nxt = mon.cnt_in;
                    if (w_match) begin
                        w_miss_run_nxt = 4'd0;
                        if (w_wrap) begin
                            w_wrap_cnt_nxt   = r_wrap_cnt + 8'd1;
                            w_wrap_pulse_nxt = 1'b1;
                        end
                    end else begin
                        w_miss_run_nxt = w_miss_inc;
                        if (mon.clr_err) begin
                            w_err_cnt_nxt = 8'd1;
                        end else if (r_err_cnt != c_cnt_max) begin
                            w_err_cnt_nxt = r_err_cnt + 8'd1;
                        end
                        if (w_miss_inc == c_miss_limit) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    if (mon.clr_err) begin
                        w_prev_nxt     = mon.cnt_in;
                        w_good_run_nxt = 4'd0;
                        w_state_nxt    = ST_SYNC;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        w_locked_nxt = (w_state_nxt == ST_TRACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev       <= 3'd0;
            r_good_run   <= 4'd0;
            r_miss_run   <= 4'd0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
            r_err_cnt    <= 8'd0;
            r_wrap_cnt   <= 8'd0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_prev       <= w_prev_nxt;
            r_good_run   <= w_good_run_nxt;
            r_miss_run   <= w_miss_run_nxt;
            r_locked     <= w_locked_nxt;
            r_err        <= w_err_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
            r_wrap_cnt   <= w_wrap_cnt_nxt;
            r_wrap_pulse <= w_wrap_pulse_nxt;
        end
    end

    assign mon.locked     = r_locked;
    assign mon.err        = r_err;
    assign mon.err_cnt    = r_err_cnt;
    assign mon.wrap_cnt   = r_wrap_cnt;
    assign mon.wrap_pulse = r_wrap_pulse;

endmodule
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_monitor
// Description : Directed, table-driven self-checking bench for count_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_monitor;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    count_monitor_if mon_if ();

    count_monitor #(
        .SYNC_LEN   (4),
        .MISS_LIMIT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       clr;
        logic [2:0] cnt;
        logic       locked;
        logic       err;
        logic [7:0] err_cnt;
        logic [7:0] wrap_cnt;
        logic       wrap_pulse;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic c, input logic [2:0] v,
                       input logic l, input logic er, input logic [7:0] ec,
                       input logic [7:0] wc, input logic wp);
        vec_t t;
        t = '{r, e, c, v, l, er, ec, wc, wp};
        tbl.push_back(t);
    endtask

    task automatic drive(input logic r, input logic e, input logic c, input logic [2:0] v);
        @(negedge clk);
        rst            = r;
        mon_if.en      = e;
        mon_if.clr_err = c;
        mon_if.cnt_in  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [2:0] v);
        drive(1'b0, 1'b1, 1'b0, v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {13'd0, mon_if.locked, mon_if.err, mon_if.err_cnt, mon_if.wrap_cnt, mon_if.wrap_pulse};
    endfunction

    function automatic logic [31:0] pack(input logic l, input logic er, input logic [7:0] ec,
                                         input logic [7:0] wc, input logic wp);
        return {13'd0, l, er, ec, wc, wp};
    endfunction

    initial begin
        logic [2:0] p;
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b1;
        mon_if.en      = 1'b0;
        mon_if.clr_err = 1'b0;
        mon_if.cnt_in  = 3'd0;

        //   rst en clr cnt   locked err ec wc wp
        add(1, 0, 0, 0,   0, 0, 0, 0, 0);   // reset
        add(0, 1, 0, 0,   0, 0, 0, 0, 0);   // IDLE -> SYNC
        add(0, 1, 0, 1,   0, 0, 0, 0, 0);
        add(0, 1, 0, 2,   0, 0, 0, 0, 0);
        add(0, 1, 0, 3,   0, 0, 0, 0, 0);
        add(0, 1, 0, 4,   1, 0, 0, 0, 0);   // locked after 4th match
        add(0, 1, 0, 5,   1, 0, 0, 0, 0);
        add(0, 1, 0, 6,   1, 0, 0, 0, 0);
        add(0, 1, 0, 7,   1, 0, 0, 0, 0);
        add(0, 1, 0, 0,   1, 0, 0, 1, 1);   // wrap pulse
        add(0, 1, 0, 1,   1, 0, 0, 1, 0);
        add(0, 1, 0, 2,   1, 0, 0, 1, 0);
        add(0, 1, 0, 3,   1, 0, 0, 1, 0);
        add(0, 1, 0, 4,   1, 0, 0, 1, 0);
        add(0, 1, 0, 5,   1, 0, 0, 1, 0);
        add(0, 1, 0, 6,   1, 0, 0, 1, 0);
        add(0, 1, 0, 3,   1, 0, 1, 1, 0);   // single miss
        add(0, 1, 0, 4,   1, 0, 1, 1, 0);   // match clears miss run
        add(0, 1, 0, 5,   1, 0, 1, 1, 0);
        add(0, 1, 0, 6,   1, 0, 1, 1, 0);
        add(0, 1, 0, 7,   1, 0, 1, 1, 0);
        add(0, 1, 0, 0,   1, 0, 1, 2, 1);
        add(0, 1, 0, 1,   1, 0, 1, 2, 0);
        add(0, 1, 0, 2,   1, 0, 1, 2, 0);
        add(0, 1, 1, 3,   1, 0, 0, 2, 0);   // clr in TRACK keeps lock
        add(0, 1, 0, 6,   1, 0, 1, 2, 0);
        add(0, 1, 0, 6,   0, 1, 2, 2, 0);   // second miss -> FAULT
        add(0, 1, 0, 7,   0, 1, 2, 2, 0);
        add(0, 1, 0, 0,   0, 1, 2, 2, 0);   // no wrap counting in FAULT
        add(0, 1, 1, 0,   0, 0, 0, 2, 0);   // clr leaves FAULT
        add(0, 1, 0, 1,   0, 0, 0, 2, 0);
        add(0, 1, 0, 2,   0, 0, 0, 2, 0);
        add(0, 1, 0, 3,   0, 0, 0, 2, 0);
        add(0, 1, 0, 4,   1, 0, 0, 2, 0);
        add(0, 1, 0, 6,   1, 0, 1, 2, 0);
        add(0, 1, 1, 6,   0, 1, 1, 2, 0);   // clr + fault entry: fault wins
        add(0, 1, 1, 2,   0, 0, 0, 2, 0);
        add(0, 1, 0, 3,   0, 0, 0, 2, 0);
        add(0, 1, 0, 4,   0, 0, 0, 2, 0);
        add(0, 1, 0, 5,   0, 0, 0, 2, 0);
        add(0, 1, 0, 6,   1, 0, 0, 2, 0);
        add(0, 1, 1, 0,   1, 0, 1, 2, 0);   // clr + miss -> err_cnt 1
        add(0, 1, 0, 1,   1, 0, 1, 2, 0);
        add(0, 0, 0, 2,   0, 0, 1, 2, 0);   // en low -> IDLE, counts held
        add(0, 0, 0, 5,   0, 0, 1, 2, 0);
        add(0, 1, 0, 5,   0, 0, 1, 2, 0);
        add(0, 1, 0, 6,   0, 0, 1, 2, 0);
        add(0, 1, 0, 7,   0, 0, 1, 2, 0);
        add(0, 1, 0, 1,   0, 0, 1, 2, 0);   // SYNC miss restarts run
        add(0, 1, 0, 2,   0, 0, 1, 2, 0);
        add(0, 1, 0, 3,   0, 0, 1, 2, 0);
        add(0, 1, 0, 4,   0, 0, 1, 2, 0);
        add(0, 1, 0, 5,   1, 0, 1, 2, 0);
        add(0, 1, 1, 6,   1, 0, 0, 2, 0);   // clr in TRACK: err_cnt only
        add(1, 1, 0, 6,   0, 0, 0, 0, 0);   // mid-run reset
        add(0, 1, 0, 0,   0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].cnt);
            chk($sformatf("vec%0d", i), outs(),
                pack(tbl[i].locked, tbl[i].err, tbl[i].err_cnt, tbl[i].wrap_cnt, tbl[i].wrap_pulse));
        end

        // Build wrap_cnt=3, err_cnt=1 while locked, then en drop and reset.
        for (int v = 1; v <= 4; v++) feed(3'(v));
        chk("relock", 32'(mon_if.locked), 32'd1);
        for (int k = 0; k < 24; k++) feed(3'((5 + k) % 8));
        feed(3'd6);
        feed(3'd7);
        chk("wrap3_err1", outs(), pack(1, 0, 8'd1, 8'd3, 0));
        drive(1'b0, 1'b0, 1'b0, 3'd0);
        chk("en_drop", outs(), pack(0, 0, 8'd1, 8'd3, 0));
        for (int v = 0; v <= 4; v++) feed(3'(v));
        chk("relock2", outs(), pack(1, 0, 8'd1, 8'd3, 0));
        drive(1'b1, 1'b1, 1'b1, 3'd5);
        chk("rst_prio", outs(), pack(0, 0, 8'd0, 8'd0, 0));

        // err_cnt saturation: alternate one miss and one match, 300 times.
        for (int v = 0; v <= 4; v++) feed(3'(v));
        p = 3'd4;
        for (int k = 0; k < 300; k++) begin
            feed(p + 3'd2);
            feed(p + 3'd3);
            p = p + 3'd3;
        end
        chk("sat_err_cnt", 32'(mon_if.err_cnt), 32'd255);
        chk("sat_locked",  32'({mon_if.locked, mon_if.err}), 32'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
